// File: rtl/dbus_req_ctrl.sv
// MEM-stage data-bus request controller: turns a load/store into a single bus request and stalls the pipe until it completes.
// Optional misalignment trap enabled by defining MISALIGN_CHECK_EN.
module dbus_req_ctrl #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_write,
    input  logic [63:0] mem_addr,
    input  logic [63:0] mem_wdata,
    input  logic [2:0]  mem_size,
    input  logic        pipe_stall,
    output logic        dreq_valid,
    output logic [63:0] dreq_addr,
    output logic [2:0]  dreq_size,
    output logic [7:0]  dreq_strobe,
    output logic [63:0] dreq_data,
    input  logic        dresp_addr_ok,
    input  logic        dresp_data_ok,
    input  logic [63:0] dresp_data,
    output logic        data_ok,
    output logic [63:0] read_data,
    output logic        handshake_stall,
    output logic        timeout_err,
    output logic        misalign_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    localparam logic [7:0] MAX_WAIT_CNT = 8'(MAX_WAIT);

    state_t      state_reg, state_next;
    logic [63:0] addr_reg;
    logic [2:0]  size_reg;
    logic        write_reg;
    logic [7:0]  strobe_reg;
    logic [63:0] data_reg;
    logic [7:0]  wait_cnt_reg;
    logic        timeout_reg;

    logic [2:0]  size_norm;
    logic [7:0]  size_mask;
    logic [7:0]  strobe_calc;
    logic [63:0] wdata_shift;
    logic [63:0] load_shift;
    logic [7:0]  wait_cnt_inc;
    logic        misaligned;
    logic        latch_req;

    // Sizes 4..7 behave as a doubleword access.
    assign size_norm = mem_size[2] ? 3'd3 : mem_size;

    always_comb begin
        case (size_norm[1:0])
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            2'd2:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    assign strobe_calc  = mem_write ? (size_mask << mem_addr[2:0]) : 8'h00;
    assign wdata_shift  = mem_wdata << {mem_addr[2:0], 3'b000};
    assign load_shift   = write_reg ? 64'h0 : (dresp_data >> {addr_reg[2:0], 3'b000});
    assign wait_cnt_inc = wait_cnt_reg + 8'd1;

`ifdef MISALIGN_CHECK_EN
    always_comb begin
        case (size_norm[1:0])
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = mem_addr[0];
            2'd2:    misaligned = |mem_addr[1:0];
            default: misaligned = |mem_addr[2:0];
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_next      = state_reg;
        latch_req       = 1'b0;
        data_ok         = 1'b0;
        read_data       = 64'h0;
        handshake_stall = 1'b0;
        misalign_err    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (mem_valid) begin
                    handshake_stall = 1'b1;
                    if (misaligned) begin
                        // Trapped access completes locally without touching the bus.
                        data_ok      = 1'b1;
                        misalign_err = 1'b1;
                        state_next   = DONE;
                    end else begin
                        latch_req  = 1'b1;
                        state_next = ADDR;
                    end
                end
            end
            ADDR: begin
                handshake_stall = 1'b1;
                if (dresp_data_ok) begin
                    data_ok    = 1'b1;
                    read_data  = load_shift;
                    state_next = DONE;
                end else if (dresp_addr_ok) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                handshake_stall = 1'b1;
                if (dresp_data_ok) begin
                    data_ok    = 1'b1;
                    read_data  = load_shift;
                    state_next = DONE;
                end
            end
            default: begin
                // DONE lets the MEM instruction retire before a new one is accepted.
                if (!pipe_stall) state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            addr_reg     <= 64'h0;
            size_reg     <= 3'd0;
            write_reg    <= 1'b0;
            strobe_reg   <= 8'h00;
            data_reg     <= 64'h0;
            wait_cnt_reg <= 8'd0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (latch_req) begin
                addr_reg     <= mem_addr;
                size_reg     <= size_norm;
                write_reg    <= mem_write;
                strobe_reg   <= strobe_calc;
                data_reg     <= wdata_shift;
                wait_cnt_reg <= 8'd0;
            end else if ((state_reg == ADDR || state_reg == DATA) && wait_cnt_reg != 8'hFF) begin
                wait_cnt_reg <= wait_cnt_inc;
                if (wait_cnt_inc >= MAX_WAIT_CNT) timeout_reg <= 1'b1;
            end
        end
    end

    assign dreq_valid  = (state_reg == ADDR);
    assign dreq_addr   = addr_reg;
    assign dreq_size   = size_reg;
    assign dreq_strobe = strobe_reg;
    assign dreq_data   = data_reg;
    assign timeout_err = timeout_reg;

endmodule

// File: tb/tb_dbus_req_ctrl.sv
// Randomized scoreboard bench for dbus_req_ctrl: driver pushes expected requests/completions, a negedge monitor pops and compares.
module tb_dbus_req_ctrl;

    localparam int MW = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid, mem_write, pipe_stall;
    logic [63:0] mem_addr, mem_wdata;
    logic [2:0]  mem_size;
    logic        dreq_valid;
    logic [63:0] dreq_addr, dreq_data;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic        dresp_addr_ok, dresp_data_ok;
    logic [63:0] dresp_data;
    logic        data_ok;
    logic [63:0] read_data;
    logic        handshake_stall, timeout_err, misalign_err;

    dbus_req_ctrl #(.MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset),
        .mem_valid(mem_valid), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_size(mem_size), .pipe_stall(pipe_stall),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .data_ok(data_ok), .read_data(read_data), .handshake_stall(handshake_stall),
        .timeout_err(timeout_err), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic        write;
    } req_t;

    typedef struct {
        logic [63:0] rdata;
        logic        to;
    } cmp_t;

    req_t req_q[$];
    cmp_t cmp_q[$];

    int   checks = 0;
    int   failures = 0;
    int   txn_count = 0;
    bit   mon_en = 0;
    bit   exp_stall = 0, exp_dvalid = 0, exp_mis = 0;
    bit   sticky_to = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: per-cycle control expectations plus scoreboard pops on bus request and completion.
    always @(negedge clk) begin
        if (mon_en) begin
            check("handshake_stall", handshake_stall, exp_stall);
            check("dreq_valid", dreq_valid, exp_dvalid);
            check("misalign_err", misalign_err, exp_mis);
            if (dreq_valid) begin
                if (req_q.size() == 0) begin
                    check("unexpected_dreq_valid", 1, 0);
                end else begin
                    check("dreq_addr", dreq_addr, req_q[0].addr);
                    check("dreq_size", dreq_size, req_q[0].size);
                    check("dreq_strobe", dreq_strobe, req_q[0].strobe);
                    if (req_q[0].write) check("dreq_data", dreq_data, req_q[0].data);
                    if (dresp_addr_ok || dresp_data_ok) void'(req_q.pop_front());
                end
            end
            if (data_ok) begin
                if (cmp_q.size() == 0) begin
                    check("unexpected_data_ok", 1, 0);
                end else begin
                    check("read_data", read_data, cmp_q[0].rdata);
                    check("timeout_err", timeout_err, cmp_q[0].to);
                    txn_count++;
                    $display("txn %0d done read_data=%h timeout_err=%0b", txn_count, read_data, timeout_err);
                    void'(cmp_q.pop_front());
                end
            end
        end
    end

    task automatic noise();
        dresp_addr_ok = 1'($urandom % 2);
        dresp_data_ok = 1'($urandom % 2);
        dresp_data    = {$urandom, $urandom};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One access: a = addr_ok cycle, d = data_ok cycle (a <= d) counted from first ADDR cycle, s = DONE stall cycles.
    task automatic do_txn(input logic wr, input logic [63:0] ad, input logic [2:0] sz,
                          input logic [63:0] wd, input int a, input int d, input int s,
                          input logic [63:0] rd, input int gap);
        int          sn = (sz > 3) ? 3 : int'(sz);
        int          off = int'(ad[2:0]);
        logic [7:0]  strb = wr ? 8'(((1 << (1 << sn)) - 1) << off) : 8'h00;
        logic [63:0] sdata = wd << (off * 8);
        logic [63:0] rexp = wr ? 64'h0 : (rd >> (off * 8));
        bit          mis = 0;
        req_t        r;
        cmp_t        c;
`ifdef MISALIGN_CHECK_EN
        mis = (ad & ((64'd1 << sn) - 64'd1)) != 64'd0;
`endif
        mem_valid = 1'b1; mem_write = wr; mem_addr = ad; mem_size = sz; mem_wdata = wd;
        pipe_stall = 1'b0;
        noise();
        exp_stall = 1; exp_dvalid = 0;
        if (mis) begin
            exp_mis = 1;
            c.rdata = 64'h0; c.to = sticky_to;
            cmp_q.push_back(c);
            tick();
            exp_mis = 0;
        end else begin
            r.addr = ad; r.size = 3'(sn); r.strobe = strb; r.data = sdata; r.write = wr;
            req_q.push_back(r);
            c.rdata = rexp; c.to = sticky_to | (d >= MW);
            cmp_q.push_back(c);
            tick();
            for (int k = 0; k <= d; k++) begin
                exp_dvalid    = (k <= a);
                dresp_addr_ok = (k == a) || (k > a && ($urandom % 2) == 1);
                dresp_data_ok = (k == d);
                dresp_data    = (k == d) ? rd : {$urandom, $urandom};
                tick();
            end
            sticky_to = c.to;
        end
        exp_dvalid = 0; exp_stall = 0;
        for (int j = 0; j <= s; j++) begin
            pipe_stall = (j < s);
            noise();
            tick();
        end
        mem_valid = 1'b0; pipe_stall = 1'b0;
        mem_addr = {$urandom, $urandom}; mem_write = 1'($urandom % 2);
        for (int g = 0; g < gap; g++) begin
            noise();
            tick();
        end
    endtask

    initial begin
        reset = 1'b1; mem_valid = 1'b0; mem_write = 1'b0; mem_addr = 64'h0;
        mem_wdata = 64'h0; mem_size = 3'd0; pipe_stall = 1'b0;
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = 64'h0;
        repeat (3) tick();
        @(negedge clk);
        check("reset_dreq_valid", dreq_valid, 0);
        check("reset_stall", handshake_stall, 0);
        check("reset_timeout", timeout_err, 0);
        check("reset_data_ok", data_ok, 0);
        check("reset_dreq_addr", dreq_addr, 0);
        tick();
        reset = 1'b0;
        mon_en = 1;

        do_txn(1'b0, 64'h80000004, 3'd2, 64'h0, 0, 0, 0, 64'h1122334455667788, 1);
        do_txn(1'b1, 64'h1003, 3'd1, 64'hBEEF, 0, 0, 0, 64'h0, 0);
        do_txn(1'b0, 64'h2000, 3'd3, 64'h0, 0, 3, 3, 64'hA5A5_0000_FFFF_1234, 2);
        for (int i = 0; i < 150; i++) begin
            int d = (($urandom % 12) == 0) ? MW + int'($urandom % 3) : int'($urandom % 5);
            int a = int'($urandom_range(0, d));
            do_txn(1'($urandom % 2), {$urandom, $urandom}, 3'($urandom % 8), {$urandom, $urandom},
                   a, d, int'($urandom % 4), {$urandom, $urandom}, int'($urandom % 3));
        end

        // Watchdog: clear the sticky flag, then leave a request unanswered and reset mid-request.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sticky_to = 0;
        begin
            req_t r;
            r.addr = 64'h40; r.size = 3'd3; r.strobe = 8'h00; r.data = 64'h0; r.write = 1'b0;
            req_q.push_back(r);
        end
        mem_valid = 1'b1; mem_write = 1'b0; mem_addr = 64'h40; mem_size = 3'd3;
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
        exp_stall = 1; exp_dvalid = 0;
        tick();
        exp_dvalid = 1;
        for (int k = 0; k <= MW; k++) begin
            @(negedge clk);
            check("watchdog_timeout", timeout_err, (k >= MW));
            tick();
        end
        reset = 1'b1; mem_valid = 1'b0;
        tick();
        reset = 1'b0;
        req_q.delete();
        exp_stall = 0; exp_dvalid = 0;
        @(negedge clk);
        check("post_reset_timeout", timeout_err, 0);
        check("post_reset_data_ok", data_ok, 0);
        check("post_reset_dreq_addr", dreq_addr, 0);
        check("post_reset_dreq_strobe", dreq_strobe, 0);
        check("post_reset_dreq_data", dreq_data, 0);
        tick();
        check("pending_completions", cmp_q.size(), 0);
        check("pending_requests", req_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
